// File: rtl/shfloat_unpack.sv
// Shared-exponent float unpacker: two-stage decode pipeline feeding a
// first-word-fall-through output FIFO with drop and bad-exponent accounting.
module shfloat_unpack #(
   parameter int unsigned INDEX_DEPTH    = 32,
   parameter int unsigned OUTPUT_DEPTH   = 32,
   parameter int unsigned MANTISSA_DEPTH = 12,
   parameter int unsigned EXPONENT_DEPTH = 8,
   parameter int unsigned PACKED_DEPTH   = 32,
   parameter int unsigned FIFO_DEPTH     = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [INDEX_DEPTH-1:0]  in_index,
   input  logic [PACKED_DEPTH-1:0] in_pack,
   input  logic                    in_strobe,
   output logic [INDEX_DEPTH-1:0]  out_index,
   output logic [OUTPUT_DEPTH-1:0] out_value_i,
   output logic [OUTPUT_DEPTH-1:0] out_value_q,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_overflow,
   output logic [15:0]             out_drop_count,
   output logic [15:0]             out_bad_exp_count
);

   localparam int unsigned AW  = $clog2(FIFO_DEPTH);
   localparam int unsigned PAD = OUTPUT_DEPTH - MANTISSA_DEPTH;
   localparam logic [EXPONENT_DEPTH-1:0] EXP_MAX = EXPONENT_DEPTH'(31);

   // Stage A
   logic                      a_strobe_q;
   logic [INDEX_DEPTH-1:0]    a_index_q;
   logic [4:0]                a_exp_q;
   logic [MANTISSA_DEPTH-1:0] a_mi_q, a_mq_q;
   logic [15:0]               bad_cnt_q;

   logic [MANTISSA_DEPTH-1:0] pack_mi, pack_mq;
   logic [EXPONENT_DEPTH-1:0] pack_exp;
   logic                      exp_bad;
   logic [4:0]                exp_d;

   always_comb begin
      pack_mi  = in_pack[PACKED_DEPTH-1 -: MANTISSA_DEPTH];
      pack_mq  = in_pack[PACKED_DEPTH-1-MANTISSA_DEPTH -: MANTISSA_DEPTH];
      pack_exp = in_pack[EXPONENT_DEPTH-1:0];
      exp_bad  = pack_exp > EXP_MAX;
      exp_d    = exp_bad ? 5'd31 : pack_exp[4:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_strobe_q <= 1'b0;
         a_index_q  <= '0;
         a_exp_q    <= '0;
         a_mi_q     <= '0;
         a_mq_q     <= '0;
         bad_cnt_q  <= '0;
      end else begin
         a_strobe_q <= in_strobe;
         if (in_strobe) begin
            a_index_q <= in_index;
            a_exp_q   <= exp_d;
            a_mi_q    <= pack_mi;
            a_mq_q    <= pack_mq;
            if (exp_bad && bad_cnt_q != 16'hFFFF)
               bad_cnt_q <= bad_cnt_q + 16'd1;
         end
      end
   end

   // Stage B
   logic                           b_strobe_q;
   logic [INDEX_DEPTH-1:0]         b_index_q;
   logic [OUTPUT_DEPTH-1:0]        b_vi_q, b_vq_q;
   logic signed [OUTPUT_DEPTH-1:0] a_wide_i, a_wide_q;
   logic [OUTPUT_DEPTH-1:0]        b_vi_d, b_vq_d;

   always_comb begin
      a_wide_i = {a_mi_q, {PAD{1'b0}}};
      a_wide_q = {a_mq_q, {PAD{1'b0}}};
      b_vi_d   = a_wide_i >>> a_exp_q;
      b_vq_d   = a_wide_q >>> a_exp_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_strobe_q <= 1'b0;
         b_index_q  <= '0;
         b_vi_q     <= '0;
         b_vq_q     <= '0;
      end else begin
         b_strobe_q <= a_strobe_q;
         if (a_strobe_q) begin
            b_index_q <= a_index_q;
            b_vi_q    <= b_vi_d;
            b_vq_q    <= b_vq_d;
         end
      end
   end

   // Output FIFO
   logic [INDEX_DEPTH-1:0]  mem_index [FIFO_DEPTH];
   logic [OUTPUT_DEPTH-1:0] mem_vi    [FIFO_DEPTH];
   logic [OUTPUT_DEPTH-1:0] mem_vq    [FIFO_DEPTH];
   logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
   logic [AW:0]             count_q, count_d;
   logic                    ovf_q;
   logic [15:0]             drop_cnt_q;
   logic                    full, pop, wr_en, drop;

   // A pop frees a slot in the same edge, so a full FIFO still accepts then.
   always_comb begin
      full    = count_q == (AW+1)'(FIFO_DEPTH);
      pop     = out_valid && out_ready;
      wr_en   = b_strobe_q && (!full || pop);
      drop    = b_strobe_q && full && !pop;
      count_d = count_q;
      if (wr_en && !pop)
         count_d = count_q + (AW+1)'(1);
      else if (!wr_en && pop)
         count_d = count_q - (AW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_index[wr_ptr_q] <= b_index_q;
         mem_vi[wr_ptr_q]    <= b_vi_q;
         mem_vq[wr_ptr_q]    <= b_vq_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         count_q <= count_d;
         if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
         if (drop) begin
            ovf_q <= 1'b1;
            if (drop_cnt_q != 16'hFFFF)
               drop_cnt_q <= drop_cnt_q + 16'd1;
         end
      end
   end

   always_comb begin
      out_valid         = count_q != '0;
      out_index         = out_valid ? mem_index[rd_ptr_q] : '0;
      out_value_i       = out_valid ? mem_vi[rd_ptr_q]    : '0;
      out_value_q       = out_valid ? mem_vq[rd_ptr_q]    : '0;
      out_overflow      = ovf_q;
      out_drop_count    = drop_cnt_q;
      out_bad_exp_count = bad_cnt_q;
   end

endmodule

// File: tb/tb_shfloat_unpack.sv
// Scoreboard bench for shfloat_unpack: stimulus queues expected entries,
// a negedge monitor compares every popped FIFO head against the queue.
module tb_shfloat_unpack;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] in_index = '0;
   logic [31:0] in_pack = '0;
   logic        in_strobe = 1'b0;
   logic [31:0] out_index, out_value_i, out_value_q;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        out_overflow;
   logic [15:0] out_drop_count, out_bad_exp_count;

   shfloat_unpack #(
      .INDEX_DEPTH(32), .OUTPUT_DEPTH(32), .MANTISSA_DEPTH(12),
      .EXPONENT_DEPTH(8), .PACKED_DEPTH(32), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_index(in_index), .in_pack(in_pack),
      .in_strobe(in_strobe), .out_index(out_index), .out_value_i(out_value_i),
      .out_value_q(out_value_q), .out_valid(out_valid), .out_ready(out_ready),
      .out_overflow(out_overflow), .out_drop_count(out_drop_count),
      .out_bad_exp_count(out_bad_exp_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] idx;
      logic [31:0] vi;
      logic [31:0] vq;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Hand-computed vectors: packed word, expected I, expected Q
   logic [31:0] vpack [8];
   logic [31:0] vexp_i[8];
   logic [31:0] vexp_q[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] idx, input int unsigned v, input bit stored);
      in_strobe = 1'b1;
      in_index  = idx;
      in_pack   = vpack[v];
      if (stored) exp_q.push_back('{idx: idx, vi: vexp_i[v], vq: vexp_q[v]});
      tick();
   endtask

   task automatic idle(input int unsigned n);
      in_strobe = 1'b0;
      for (int unsigned k = 0; k < n; k++) tick();
   endtask

   task automatic wait_drain(input string name);
      int unsigned n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 60) begin
         tick();
         n++;
      end
      check(name, 64'(exp_q.size()), 64'd0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_pop", {32'd0, out_index}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("pop_index", 64'(out_index), 64'(e.idx));
               check("pop_value_i", 64'(out_value_i), 64'(e.vi));
               check("pop_value_q", 64'(out_value_q), 64'(e.vq));
            end
         end else if (!out_valid) begin
            check("idle_zero", {out_value_i, out_value_q}, 64'd0);
         end
      end
   end

   initial begin
      vpack  = '{32'h7FF00001, 32'h80080014, 32'h7FF7FF40, 32'h00100000,
                 32'hFFF80001, 32'h12345604, 32'h8001FF1F, 32'h00100020};
      vexp_i = '{32'h3FF80000, 32'hFFFFF800, 32'h00000000, 32'h00100000,
                 32'hFFF80000, 32'h01230000, 32'hFFFFFFFF, 32'h00000000};
      vexp_q = '{32'h00000000, 32'hFFFFF800, 32'h00000000, 32'h00000000,
                 32'hC0000000, 32'h04560000, 32'h00000000, 32'h00000000};

      // Reset state
      #12;
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_values", {out_value_i, out_index}, 64'd0);
      check("rst_counts", {32'd0, out_drop_count, out_bad_exp_count}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // First-word latency of 3 edges
      out_ready = 1'b1;
      send(32'd5, 0, 1'b1);
      idle(1);
      check("latency_early", 64'(out_valid), 64'd0);
      idle(1);
      check("latency_valid", 64'(out_valid), 64'd1);
      check("latency_index", 64'(out_index), 64'd5);
      wait_drain("drain_first");

      // Back-to-back throughput including clamp and boundary exponents
      for (int unsigned v = 1; v < 8; v++) send(32'(v), v, 1'b1);
      idle(0);
      wait_drain("drain_burst");
      check("bad_exp_count", 64'(out_bad_exp_count), 64'd2);
      check("no_drop_yet", {out_drop_count, 15'd0, out_overflow}, 64'd0);

      // Head held stable while not ready
      out_ready = 1'b0;
      send(32'd9, 4, 1'b1);
      idle(2);
      for (int k = 0; k < 4; k++) begin
         check("hold_index", 64'(out_index), 64'd9);
         check("hold_value", {out_value_i, out_value_q}, 64'hFFF80000_C0000000);
         tick();
      end
      out_ready = 1'b1;
      wait_drain("drain_hold");

      // Overflow: six strobes into a 4-entry FIFO with no consumer
      out_ready = 1'b0;
      for (int unsigned i = 0; i < 6; i++) send(32'(i), 5, i < 4);
      idle(3);
      check("ovf_drop_count", 64'(out_drop_count), 64'd2);
      check("ovf_flag", 64'(out_overflow), 64'd1);
      check("ovf_head", 64'(out_index), 64'd0);
      out_ready = 1'b1;
      wait_drain("drain_ovf");

      // Full FIFO with simultaneous pop accepts each write
      out_ready = 1'b0;
      for (int unsigned i = 0; i < 12; i++) begin
         if (i == 6) out_ready = 1'b1;
         send(32'(10 + i), 3, 1'b1);
      end
      idle(0);
      wait_drain("drain_fullpop");
      check("fullpop_drop_count", 64'(out_drop_count), 64'd2);

      // Asynchronous reset mid-cycle discards queued words
      out_ready = 1'b0;
      send(32'd30, 0, 1'b0);
      send(32'd31, 1, 1'b0);
      idle(4);
      check("pre_rst_valid", 64'(out_valid), 64'd1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      check("arst_valid", 64'(out_valid), 64'd0);
      check("arst_flags", {out_drop_count, out_bad_exp_count, 31'd0, out_overflow}, 64'd0);
      check("arst_values", {out_value_i, out_index}, 64'd0);
      tick();
      send(32'd99, 2, 1'b0);
      idle(1);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("post_rst_valid", 64'(out_valid), 64'd0);
      out_ready = 1'b1;
      send(32'd77, 1, 1'b1);
      idle(0);
      wait_drain("drain_post_rst");
      check("post_rst_counts", {out_drop_count, out_bad_exp_count, 31'd0, out_overflow}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/shfloat_unpack.md
SHFLOAT_UNPACK -- requirements
Module: shfloat_unpack

Interface
REQ-001 Parameter INDEX_DEPTH, default 32, width of the sample index.
REQ-002 Parameter OUTPUT_DEPTH, default 32, width of each reconstructed I/Q value.
REQ-003 Parameter MANTISSA_DEPTH, default 12, bits per packed mantissa.
REQ-004 Parameter EXPONENT_DEPTH, default 8, bits of the shared-exponent field.
REQ-005 Parameter PACKED_DEPTH, default 32, width of the packed word.
REQ-006 Parameter FIFO_DEPTH, default 4, output FIFO entries (power of two).
REQ-007 clk  input  1  single clock; one clock, all logic on rising edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 in_index  input  INDEX_DEPTH  index accompanying the packed word.
REQ-010 in_pack  input  PACKED_DEPTH  packed word: I mantissa [31:20], Q mantissa [19:8], exponent [7:0].
REQ-011 in_strobe  input  1  one-cycle qualifier; no backpressure toward the source.
REQ-012 out_index  output  INDEX_DEPTH  index of the FIFO head entry.
REQ-013 out_value_i  output  OUTPUT_DEPTH  reconstructed signed I at FIFO head.
REQ-014 out_value_q  output  OUTPUT_DEPTH  reconstructed signed Q at FIFO head.
REQ-015 out_valid  output  1  FIFO head holds a valid entry.
REQ-016 out_ready  input  1  consumer accepts head when out_valid && out_ready at a rising edge.
REQ-017 out_overflow  output  1  sticky flag: at least one decoded word was dropped.
REQ-018 out_drop_count  output  16  saturating count of dropped words.
REQ-019 out_bad_exp_count  output  16  saturating count of words with exponent field > 31.

Function
REQ-020 Stage A SHALL register in_index, the exponent field and both mantissas on each edge where in_strobe is 1; a_strobe follows in_strobe.
REQ-021 Effective exponent e SHALL equal the exponent field when <= 31, else 31, with out_bad_exp_count incremented by one in stage A.
REQ-022 Stage B SHALL compute I = {mantissa_i, 20 zero bits} arithmetically shifted right by e (sign-extending), Q likewise from mantissa_q.
REQ-023 Stage B result SHALL be written into the FIFO on the following edge; total latency from in_strobe edge to out_valid high with an empty FIFO SHALL be 3 rising edges.
REQ-024 The FIFO SHALL be first-word-fall-through; out_index/out_value_i/out_value_q SHALL be stable while out_valid && !out_ready.
REQ-025 Entries SHALL leave in arrival order; a pop occurs only on out_valid && out_ready.
REQ-026 Write when full with no simultaneous pop: word dropped, out_overflow set, out_drop_count incremented.
REQ-027 Write when full with simultaneous pop: word accepted, no drop recorded.
REQ-028 Write and pop on an empty FIFO: entry stored; out_valid rises on the next edge (no bypass).
REQ-029 Both counters SHALL saturate at 16'hFFFF and never wrap.
REQ-030 Pipeline SHALL accept in_strobe every cycle (throughput one word per clock).
REQ-031 out_value_i/out_value_q SHALL read zero while out_valid is 0.

Reset
REQ-032 rst_n low SHALL asynchronously clear pipeline strobes, FIFO pointers and occupancy, out_valid, out_overflow and both counters, and SHALL zero out_index, out_value_i and out_value_q.
REQ-033 Words in flight or stored when rst_n falls SHALL be discarded; first accepted in_strobe after rst_n rises SHALL be the first word out.
REQ-034 in_strobe asserted while rst_n is low SHALL be ignored.

Verification
REQ-035 in_pack 0x7FF00001, index 5, out_ready 1 -> after 3 edges out_valid 1, out_index 5, I 0x3FF80000, Q 0x00000000.
REQ-036 in_pack 0x80080014 -> I 0xFFFFF800, Q 0xFFFFF800 (sign extension, e=20).
REQ-037 in_pack 0x7FF7FF40 -> e clamped to 31, I 0, Q 0, out_bad_exp_count 1.
REQ-038 out_ready 0, six back-to-back strobes (indices 0..5) -> 4 stored, out_drop_count 2, out_overflow 1; out_ready 1 then yields indices 0,1,2,3 in order.
REQ-039 FIFO full, out_ready 1 held, continuous strobes -> no drops, out_drop_count unchanged, order preserved.
REQ-040 Two entries queued, rst_n pulsed low mid-cycle -> out_valid 0 immediately, counters 0, out_overflow 0; next strobe after release emerges first.
